multiply_seq: RTL and testbench
===============================

Name: multiply_seq

Overview:
- Sequential shift-add multiplier that reverses the fixed-point divide path. It takes an I8F8 quotient and an I8F0 divisor and rebuilds the I16F8 product. It also returns the product rounded to an I8F0 dividend.
- Sits beside the combinational divider in the common library. Used for reconstruction checks (a ≈ c*b) and wherever an area-cheap multiply is acceptable.
- Valid/ready handshake on both input and output.

Parameters:
- DATA_WD, 8, integer width of divisor and dividend; number of iteration cycles
- FRAC_WD, 8, fractional bits of the quotient input and of the product

Ports:
- clk  input  1  clock; all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- val_i  input  1  input valid
- rdy_o  output  1  input ready
- dat_c_i  input  DATA_WD+FRAC_WD  quotient, unsigned I8F8
- dat_b_i  input  DATA_WD  divisor, unsigned I8F0
- val_o  output  1  result valid
- rdy_i  input  1  result ready (downstream)
- dat_p_o  output  2*DATA_WD+FRAC_WD  full product, unsigned I16F8
- dat_a_o  output  DATA_WD  rounded and saturated product, unsigned I8F0
- sat_o  output  1  high when dat_a_o is saturated

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; accumulator, operand registers and counter = 0.
  - val_o = 0; dat_p_o = 0; dat_a_o = 0; sat_o = 0.
  - rdy_o = (state==IDLE), so it reads 1 during and after reset.
- States:
  - IDLE: rdy_o = 1. Accept on a rising edge with val_i & rdy_o.
    - Latch multiplicand = dat_c_i, zero-extended to 2*DATA_WD+FRAC_WD bits.
    - Latch multiplier = dat_b_i; clear accumulator and counter; go to BUSY.
  - BUSY: rdy_o = 0; val_i is ignored. On each edge:
    - If multiplier[0] = 1, accumulator += multiplicand.
    - Then multiplicand <<= 1, multiplier >>= 1, counter += 1.
    - After the DATA_WD-th BUSY edge, go to DONE.
  - DONE: val_o = 1; outputs are stable and held while rdy_i = 0.
    - On an edge with val_o & rdy_i, go to IDLE.
    - No new accept on that same edge.
- Latency and throughput:
  - Accept edge T; val_o first visible in the cycle after edge T+DATA_WD.
  - Minimum accept-to-accept interval is DATA_WD+2 cycles.
- Output arithmetic:
  - dat_p_o = dat_c_i * dat_b_i, exact; max 0xFEFF01 fits in 24 bits, no overflow.
  - Rounding: r = (dat_p_o + 2^(FRAC_WD-1)) >> FRAC_WD, computed 1 bit wider. Round half up.
  - If r > 2^DATA_WD - 1: dat_a_o = all ones, sat_o = 1. Otherwise dat_a_o = r, sat_o = 0.
  - dat_p_o, dat_a_o and sat_o are valid only while val_o = 1. They hold their last values in IDLE and BUSY until the next DONE.
- Boundaries:
  - dat_b_i = 0 or dat_c_i = 0: still takes the full DATA_WD cycles; result 0.
  - rdy_i held high early, before val_o: no effect.
  - val_i dropped while in BUSY: no effect; the operands are already latched.
  - rstn asserted mid-operation in any state: immediate return to the reset values and the in-flight result is lost. After release, the first accept needs val_i high on a clean edge.
  - val_i high continuously: the next operand is accepted on the first edge after returning to IDLE.

Test Plan:
- Basic: reset; c=0x0280 (2.5), b=0x04, rdy_i=1 → val_o in the cycle after edge T+8; dat_p_o=0x000A00, dat_a_o=0x0A, sat_o=0; rdy_o returns to 1 one cycle later.
- Rounding:
  - c=0x0155, b=0x03 → dat_p_o=0x0003FF, dat_a_o=0x04.
  - c=0x0080, b=0x01 → dat_p_o=0x000080, dat_a_o=0x01 (half rounds up).
  - c=0x007F, b=0x01 → dat_a_o=0x00.
- Saturation: c=0xFFFF, b=0xFF → dat_p_o=0xFEFF01, dat_a_o=0xFF, sat_o=1. Also c=0x0100, b=0xFF → dat_a_o=0xFF, sat_o=0.
- Backpressure: hold rdy_i=0 for 5 cycles after val_o rises → val_o and outputs stable; rdy_o=0; a new val_i with different data is ignored. Raise rdy_i → one handshake, then IDLE.
- Zero and back-to-back: b=0x00 with c=0x1234 → result 0 after 8 BUSY cycles. With val_i held high for three operand sets, accepts are spaced exactly 10 cycles apart and every result is correct.
- Reset mid-op: drop rstn asynchronously at BUSY cycle 4 → val_o=0 and outputs 0 immediately; rdy_o=1. Release and issue c=0x0200, b=0x03 → dat_a_o=0x06.

Source files
------------

// File: rtl/multiply_seq.sv
// Sequential shift-add multiplier: unsigned I8F8 quotient times I8F0 divisor gives an I16F8
// product, plus that product rounded half-up and saturated to an I8F0 dividend.
module multiply_seq #(
    parameter int unsigned DATA_WD = 8,
    parameter int unsigned FRAC_WD = 8
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           val_i,
    output logic                           rdy_o,
    input  logic [DATA_WD+FRAC_WD-1:0]     dat_c_i,
    input  logic [DATA_WD-1:0]             dat_b_i,
    output logic                           val_o,
    input  logic                           rdy_i,
    output logic [2*DATA_WD+FRAC_WD-1:0]   dat_p_o,
    output logic [DATA_WD-1:0]             dat_a_o,
    output logic                           sat_o
);

    localparam int unsigned P_WD   = 2 * DATA_WD + FRAC_WD;
    localparam int unsigned R_WD   = 2 * DATA_WD + 1;
    localparam int unsigned CNT_WD = $clog2(DATA_WD + 1);
    localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(DATA_WD - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic [P_WD-1:0]      mcand_q, mcand_d;
    logic [DATA_WD-1:0]   mplier_q, mplier_d;
    logic [P_WD-1:0]      acc_q, acc_d;
    logic [CNT_WD-1:0]    cnt_q, cnt_d;
    logic [P_WD-1:0]      dat_p_q, dat_p_d;
    logic [DATA_WD-1:0]   dat_a_q, dat_a_d;
    logic                 sat_q, sat_d;

    logic [P_WD-1:0]      acc_sum;
    logic [R_WD-1:0]      rnd;
    logic                 rnd_ovf;

    // Final-step sum feeds both the accumulator and the result registers on the last edge.
    always_comb begin
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
        // (p + half) >> FRAC_WD == (p >> FRAC_WD) + p[FRAC_WD-1]
        rnd     = {1'b0, acc_sum[P_WD-1:FRAC_WD]} + R_WD'(acc_sum[FRAC_WD-1]);
        rnd_ovf = |rnd[R_WD-1:DATA_WD];
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dat_p_d  = dat_p_q;
        dat_a_d  = dat_a_q;
        sat_d    = sat_q;

        unique case (state_q)
            StIdle: begin
                if (val_i) begin
                    mcand_d  = {{DATA_WD{1'b0}}, dat_c_i};
                    mplier_d = dat_b_i;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = StBusy;
                end
            end
            StBusy: begin
                acc_d    = acc_sum;
                mcand_d  = {mcand_q[P_WD-2:0], 1'b0};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    dat_p_d = acc_sum;
                    dat_a_d = rnd_ovf ? '1 : rnd[DATA_WD-1:0];
                    sat_d   = rnd_ovf;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (rdy_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= StIdle;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            dat_p_q  <= '0;
            dat_a_q  <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            dat_p_q  <= dat_p_d;
            dat_a_q  <= dat_a_d;
            sat_q    <= sat_d;
        end
    end

    assign rdy_o   = (state_q == StIdle);
    assign val_o   = (state_q == StDone);
    assign dat_p_o = dat_p_q;
    assign dat_a_o = dat_a_q;
    assign sat_o   = sat_q;

endmodule

// File: tb/tb_multiply_seq.sv
// Scoreboard bench for multiply_seq: expected results queued at accept, compared at handshake.
module tb_multiply_seq;

    logic        clk;
    logic        rstn;
    logic        val_i;
    logic        rdy_o;
    logic [15:0] dat_c_i;
    logic [7:0]  dat_b_i;
    logic        val_o;
    logic        rdy_i;
    logic [23:0] dat_p_o;
    logic [7:0]  dat_a_o;
    logic        sat_o;

    typedef struct {
        logic [23:0] p;
        logic [7:0]  a;
        logic        sat;
        int          acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_results = 0;
    int   target    = 0;
    int   cyc       = 0;
    int   last_acc  = -1;
    bit   b2b_en    = 0;
    logic val_prev  = 0;

    multiply_seq #(
        .DATA_WD (8),
        .FRAC_WD (8)
    ) u_dut (
        .clk     (clk),
        .rstn    (rstn),
        .val_i   (val_i),
        .rdy_o   (rdy_o),
        .dat_c_i (dat_c_i),
        .dat_b_i (dat_b_i),
        .val_o   (val_o),
        .rdy_i   (rdy_i),
        .dat_p_o (dat_p_o),
        .dat_a_o (dat_a_o),
        .sat_o   (sat_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Accept and result monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rstn) begin
            if (val_i && rdy_o) begin
                exp_t        e;
                logic [24:0] r;
                e.p = {8'b0, dat_c_i} * {16'b0, dat_b_i};
                r   = ({1'b0, e.p} + 25'd128) >> 8;
                e.sat = (r > 25'd255);
                e.a   = e.sat ? 8'hFF : r[7:0];
                e.acc_cyc = cyc;
                if (b2b_en && last_acc >= 0) check_eq("b2b_spacing", 32'(cyc - last_acc), 32'd10);
                last_acc = cyc;
                sb.push_back(e);
            end
            if (val_o && !val_prev && sb.size() > 0)
                check_eq("latency", 32'(cyc - sb[0].acc_cyc), 32'd9);
            if (val_o && rdy_i) begin
                if (sb.size() == 0) begin
                    check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("dat_p", 32'(dat_p_o), 32'(e.p));
                    check_eq("dat_a", 32'(dat_a_o), 32'(e.a));
                    check_eq("sat",   32'(sat_o),   32'(e.sat));
                end
                n_results++;
            end
        end
        val_prev <= val_o;
    end

    task automatic send(input logic [15:0] c, input logic [7:0] b);
        bit ok;
        ok = 0;
        dat_c_i = c;
        dat_b_i = b;
        val_i   = 1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (rdy_o) ok = 1;
        end
        if (!ok) check_eq("accept_timeout", 32'(ok), 32'd1);
        @(posedge clk);
        #2 val_i = 0;
    endtask

    task automatic wait_results(input int want);
        for (int i = 0; i < 60 && n_results < want; i++) @(negedge clk);
        if (n_results < want) check_eq("result_timeout", 32'(n_results), 32'(want));
        @(posedge clk);
        #2;
    endtask

    task automatic run_one(input logic [15:0] c, input logic [7:0] b);
        send(c, b);
        target++;
        wait_results(target);
    endtask

    initial begin
        rstn = 0; val_i = 0; rdy_i = 0; dat_c_i = '0; dat_b_i = '0;
        repeat (2) @(posedge clk);
        #2;
        check_eq("rst_rdy_o", 32'(rdy_o), 32'd1);
        check_eq("rst_val_o", 32'(val_o), 32'd0);
        check_eq("rst_dat_p", 32'(dat_p_o), 32'd0);
        check_eq("rst_dat_a", 32'(dat_a_o), 32'd0);
        check_eq("rst_sat",   32'(sat_o),   32'd0);
        rstn = 1;
        @(posedge clk);
        #2 rdy_i = 1;

        run_one(16'h0280, 8'h04);
        @(negedge clk);
        check_eq("idle_rdy_o", 32'(rdy_o), 32'd1);
        check_eq("idle_val_o", 32'(val_o), 32'd0);
        @(posedge clk);
        #2;
        run_one(16'h0155, 8'h03);
        run_one(16'h0080, 8'h01);
        run_one(16'h007F, 8'h01);
        run_one(16'hFFFF, 8'hFF);
        run_one(16'h0100, 8'hFF);
        run_one(16'h1234, 8'h00);
        run_one(16'h0000, 8'h55);

        // Backpressure: result must hold and new input must be ignored.
        rdy_i = 0;
        send(16'h0321, 8'h07);
        for (int i = 0; i < 40 && !val_o; i++) @(negedge clk);
        check_eq("bp_val_rise", 32'(val_o), 32'd1);
        @(posedge clk);
        #2;
        val_i = 1; dat_c_i = 16'hAAAA; dat_b_i = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_val_o", 32'(val_o), 32'd1);
            check_eq("bp_dat_p", 32'(dat_p_o), 32'h0015E7);
            check_eq("bp_dat_a", 32'(dat_a_o), 32'h16);
            check_eq("bp_rdy_o", 32'(rdy_o), 32'd0);
        end
        @(posedge clk);
        #2 val_i = 0; rdy_i = 1;
        target++;
        wait_results(target);
        @(negedge clk);
        check_eq("bp_after_val_o", 32'(val_o), 32'd0);
        check_eq("bp_after_rdy_o", 32'(rdy_o), 32'd1);
        check_eq("bp_sb_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #2;

        // Back-to-back with val_i held high.
        b2b_en = 1;
        last_acc = -1;
        dat_c_i = 16'h1234; dat_b_i = 8'h56; val_i = 1;
        for (int k = 0; k < 3; k++) begin
            bit ok;
            ok = 0;
            for (int i = 0; i < 40 && !ok; i++) begin
                @(negedge clk);
                if (rdy_o) ok = 1;
            end
            if (!ok) check_eq("b2b_accept_timeout", 32'(ok), 32'd1);
            @(posedge clk);
            #2;
            if (k == 0) begin dat_c_i = 16'h00FF; dat_b_i = 8'h02; end
            if (k == 1) begin dat_c_i = 16'h0001; dat_b_i = 8'hFF; end
            if (k == 2) val_i = 0;
        end
        target += 3;
        wait_results(target);
        b2b_en = 0;

        // Asynchronous reset in BUSY.
        send(16'h0500, 8'h09);
        repeat (3) @(posedge clk);
        #2 rstn = 0;
        #1;
        check_eq("mid_rst_val_o", 32'(val_o), 32'd0);
        check_eq("mid_rst_dat_p", 32'(dat_p_o), 32'd0);
        check_eq("mid_rst_dat_a", 32'(dat_a_o), 32'd0);
        check_eq("mid_rst_sat",   32'(sat_o),   32'd0);
        check_eq("mid_rst_rdy_o", 32'(rdy_o), 32'd1);
        sb.delete();
        @(posedge clk);
        #2 rstn = 1;
        @(posedge clk);
        #2;
        run_one(16'h0200, 8'h03);
        check_eq("final_dat_a", 32'(dat_a_o), 32'h06);
        check_eq("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
